// File: rtl/irq_pending_ctrl.sv
// Interrupt front end: rising-edge capture into a pending register, enable mask,
// fixed-priority selection (bit 7 highest) and a valid/ack ID handshake.
module irq_pending_ctrl #(
    parameter int N    = 8,
    parameter int ID_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    irq_in,
    input  logic [N-1:0]    mask_in,
    output logic [N-1:0]    pend_vec,
    output logic            irq_valid,
    output logic [ID_W-1:0] irq_id,
    input  logic            irq_ack,
    output logic [N-1:0]    overrun
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t         state_r;
    logic [N-1:0]   irq_q_r;
    logic [N-1:0]   pending_r;
    logic [N-1:0]   edge_s;
    logic [N-1:0]   clr_s;
    logic [N-1:0]   pending_nxt_s;
    logic [N-1:0]   overrun_nxt_s;
    logic           xfer_s;
    logic           any_pend_s;
    logic [ID_W-1:0] win_id_s;

    // Highest set index wins, same rule as the downstream priority_encoder.
    function automatic logic [ID_W-1:0] prio_enc(input logic [N-1:0] vec);
        logic [ID_W-1:0] id;
        id = {ID_W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                id = i[ID_W-1:0];
            end else begin
                id = id;
            end
        end
        return id;
    endfunction

    function automatic logic [N-1:0] onehot(input logic [ID_W-1:0] id);
        logic [N-1:0] oh;
        for (int i = 0; i < N; i++) begin
            oh[i] = (id == i[ID_W-1:0]);
        end
        return oh;
    endfunction

    // Edge detect, clear decode, next-state of pending and overrun flags.
    always_comb begin
        edge_s     = irq_in & ~irq_q_r;
        xfer_s     = irq_valid & irq_ack;
        if (xfer_s) begin
            clr_s = onehot(irq_id);
        end else begin
            clr_s = {N{1'b0}};
        end
        // Set is applied after clear so a fresh edge survives its own ack.
        pending_nxt_s = (pending_r & ~clr_s) | edge_s;
        overrun_nxt_s = (overrun & ~clr_s) | (edge_s & pending_r & ~clr_s);
        pend_vec      = pending_r & mask_in;
        any_pend_s    = |pend_vec;
        win_id_s      = prio_enc(pend_vec);
    end

    // Request line history, pending register and sticky overrun flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q_r   <= {N{1'b0}};
            pending_r <= {N{1'b0}};
            overrun   <= {N{1'b0}};
        end else begin
            irq_q_r   <= irq_in;
            pending_r <= pending_nxt_s;
            overrun   <= overrun_nxt_s;
        end
    end

    // Grant handshake: once presented, an ID stays up until acked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            irq_valid <= 1'b0;
            irq_id    <= {ID_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_pend_s) begin
                        state_r   <= ST_REQ;
                        irq_valid <= 1'b1;
                        irq_id    <= win_id_s;
                    end else begin
                        state_r   <= ST_IDLE;
                        irq_valid <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (irq_ack) begin
                        state_r   <= ST_IDLE;
                        irq_valid <= 1'b0;
                    end else begin
                        state_r   <= ST_REQ;
                        irq_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    irq_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
